pc_branch_unit: RTL and testbench

// - Consumes the sign-extended branch offset (pcOffsetFilled) produced by operation prep; owns the program counter.
// - Resolves B / CBZ / CBNZ, computes branch target, redirects fetch, squashes wrong-path fetches with a flush window.
// - Sits between operation prep/ALU (branch info, zero flag) and instruction fetch (pc, fetchValid).

---
 rtl/arm_lp_pkg.sv | 14 +
 rtl/branch_target_calc.sv | 20 ++
 rtl/pc_branch_unit.sv | 135 +++++++++++++
 tb/tb_pc_branch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_lp_pkg.sv
// Shared definitions for the low-power ARM-subset core: unit state encoding and fetch constants.
package arm_lp_pkg;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2,
        StHalt  = 2'd3
    } pcu_state_e;

    localparam int unsigned INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch resolution: target address and taken decision for B / CBZ / CBNZ.
module branch_target_calc (
    input  logic        branch_valid,
    input  logic        uncond_branch,
    input  logic        cond_branch,
    input  logic        cond_invert,
    input  logic        zero_flag,
    input  logic [31:0] branch_pc,
    input  logic [31:0] pc_offset,
    output logic [31:0] target,
    output logic        taken
);

    // Word offset to byte offset; bits shifted past bit 31 are dropped.
    assign target = branch_pc + (pc_offset << 2);

    assign taken = branch_valid &
                   (uncond_branch | (cond_branch & (zero_flag ^ cond_invert)));

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter owner: resolves branches, redirects fetch and holds a flush window afterwards.
module pc_branch_unit
    import arm_lp_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   stall,
    input  logic                   halt,
    input  logic                   branchValid,
    input  logic                   uncondBranch,
    input  logic                   condBranch,
    input  logic                   condInvert,
    input  logic                   zeroFlag,
    input  logic [31:0]            branchPC,
    input  logic [31:0]            pcOffsetFilled,
    output logic [31:0]            pc,
    output logic                   fetchValid,
    output logic                   flush,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] takenCount
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    pcu_state_e             state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic                   fetch_valid_q, fetch_valid_d;
    logic                   flush_q, flush_d;
    logic                   halted_q, halted_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [3:0]             flush_cnt_q, flush_cnt_d;

    logic [31:0] target;
    logic        taken;

    branch_target_calc u_target_calc (
        .branch_valid  (branchValid),
        .uncond_branch (uncondBranch),
        .cond_branch   (condBranch),
        .cond_invert   (condInvert),
        .zero_flag     (zeroFlag),
        .branch_pc     (branchPC),
        .pc_offset     (pcOffsetFilled),
        .target        (target),
        .taken         (taken)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = flush_q;
        halted_d      = halted_q;
        count_d       = count_q;
        flush_cnt_d   = flush_cnt_q;

        unique case (state_q)
            StBoot: begin
                state_d       = StRun;
                fetch_valid_d = 1'b1;
            end
            StRun: begin
                if (halt) begin
                    state_d       = StHalt;
                    fetch_valid_d = 1'b0;
                    flush_d       = 1'b0;
                    halted_d      = 1'b1;
                end else if (stall) begin
                    fetch_valid_d = 1'b0;
                end else if (taken) begin
                    state_d       = StFlush;
                    pc_d          = target;
                    flush_d       = 1'b1;
                    fetch_valid_d = 1'b0;
                    flush_cnt_d   = FLUSH_INIT;
                    if (!(&count_q)) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                end else begin
                    pc_d          = pc_q + 32'(INSTR_BYTES);
                    fetch_valid_d = 1'b1;
                end
            end
            StFlush: begin
                if (halt) begin
                    state_d       = StHalt;
                    fetch_valid_d = 1'b0;
                    flush_d       = 1'b0;
                    halted_d      = 1'b1;
                end else if (flush_cnt_q == 4'd0) begin
                    state_d       = StRun;
                    flush_d       = 1'b0;
                    fetch_valid_d = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            StHalt: begin
                // Only reset leaves HALT.
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StBoot;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            halted_q      <= 1'b0;
            count_q       <= '0;
            flush_cnt_q   <= 4'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            halted_q      <= halted_d;
            count_q       <= count_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign pc         = pc_q;
    assign fetchValid = fetch_valid_q;
    assign flush      = flush_q;
    assign halted     = halted_q;
    assign takenCount = count_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: vector table, directed corner sequences, random vs model.
module tb_pc_branch_unit;

    localparam int unsigned FC   = 2;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          stall = 1'b0, halt = 1'b0;
    logic          bv = 1'b0, ub = 1'b0, cb = 1'b0, inv = 1'b0, zero = 1'b0;
    logic [31:0]   bpc = '0, off = '0;
    logic [31:0]   pc;
    logic          fetchValid, flush, halted;
    logic [CW-1:0] takenCount;

    int n_checks = 0;
    int n_pass   = 0;

    pc_branch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .FLUSH_CYCLES (FC),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .stall          (stall),
        .halt           (halt),
        .branchValid    (bv),
        .uncondBranch   (ub),
        .condBranch     (cb),
        .condInvert     (inv),
        .zeroFlag       (zero),
        .branchPC       (bpc),
        .pcOffsetFilled (off),
        .pc             (pc),
        .fetchValid     (fetchValid),
        .flush          (flush),
        .halted         (halted),
        .takenCount     (takenCount)
    );

    always #5 clock = ~clock;

    // Reference model: remaining boot/flush cycles tracked as plain counters.
    logic [31:0] m_pc;
    logic        m_fv, m_flush, m_halted;
    int          m_cnt, m_left;
    bit          m_boot;

    task automatic model_reset();
        m_pc = 32'h0; m_fv = 0; m_flush = 0; m_halted = 0;
        m_cnt = 0; m_left = 0; m_boot = 1;
    endtask

    task automatic model_step();
        if (m_halted) return;
        if (m_boot) begin
            m_boot = 0; m_fv = 1;
            return;
        end
        if (halt) begin
            m_halted = 1; m_fv = 0; m_flush = 0; m_left = 0;
            return;
        end
        if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_flush = 0; m_fv = 1;
            end
            return;
        end
        if (stall) begin
            m_fv = 0;
        end else if (bv && (ub || (cb && (zero != inv)))) begin
            m_pc    = bpc + off * 32'd4;
            m_flush = 1; m_fv = 0; m_left = FC;
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        end else begin
            m_pc = m_pc + 32'd4; m_fv = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        stall = 0; halt = 0; bv = 0; ub = 0; cb = 0; inv = 0; zero = 0;
        bpc = '0; off = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic set_branch(input logic u, input logic c, input logic i, input logic z,
                              input logic [31:0] p, input logic [31:0] o);
        bv = 1; ub = u; cb = c; inv = i; zero = z; bpc = p; off = o;
    endtask

    typedef struct {
        logic        v, u, c, i, z;
        logic [31:0] p, o;
        logic [31:0] exp_pc;
        logic        exp_flush, exp_fv;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1, 1, 0, 0, 0, 32'h100, 32'hFFFF_FFFC, 32'hF0, 1, 0};
        vecs[1] = '{1, 0, 1, 0, 1, 32'h20, 32'h3, 32'h2C, 1, 0};
        vecs[2] = '{1, 0, 1, 0, 0, 32'h20, 32'h3, 32'h4, 0, 1};
        vecs[3] = '{1, 0, 1, 1, 0, 32'h20, 32'h3, 32'h2C, 1, 0};
        vecs[4] = '{1, 0, 1, 1, 1, 32'h20, 32'h3, 32'h4, 0, 1};
        vecs[5] = '{1, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h8, 32'h10, 1, 0};
        vecs[6] = '{1, 1, 1, 0, 0, 32'h40, 32'h2, 32'h48, 1, 0};
        vecs[7] = '{0, 1, 0, 0, 0, 32'h40, 32'h2, 32'h4, 0, 1};
        vecs[8] = '{1, 0, 0, 0, 1, 32'h40, 32'h2, 32'h4, 0, 1};
        vecs[9] = '{1, 1, 0, 0, 0, 32'h0, 32'h4000_0002, 32'h8, 1, 0};

        model_reset();
        do_reset();

        // Single-cycle branch vectors, each from a fresh RUN state at pc=0.
        foreach (vecs[k]) begin
            do_reset();
            tick();
            set_branch(vecs[k].u, vecs[k].c, vecs[k].i, vecs[k].z, vecs[k].p, vecs[k].o);
            bv = vecs[k].v;
            tick();
            chk($sformatf("vec%0d pc", k), pc, vecs[k].exp_pc);
            chk($sformatf("vec%0d flush", k), 32'(flush), 32'(vecs[k].exp_flush));
            chk($sformatf("vec%0d fetchValid", k), 32'(fetchValid), 32'(vecs[k].exp_fv));
            clear_inputs();
        end

        // Asynchronous reset mid-run at pc=0x40, then boot sequence.
        do_reset();
        for (int n = 0; n < 17; n++) tick();
        chk("run pc 0x40", pc, 32'h40);
        #2 reset_n = 0;
        #1;
        chk("async rst pc", pc, 32'h0);
        chk("async rst fetchValid", 32'(fetchValid), 32'h0);
        chk("async rst takenCount", 32'(takenCount), 32'h0);
        chk("async rst flush", 32'(flush), 32'h0);
        chk("async rst halted", 32'(halted), 32'h0);
        model_reset();
        @(negedge clock);
        reset_n = 1;
        chk("boot pc", pc, 32'h0);
        chk("boot fetchValid", 32'(fetchValid), 32'h0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("post-boot pc%0d", n), pc, 32'(n * 4));
            chk($sformatf("post-boot fv%0d", n), 32'(fetchValid), 32'h1);
        end

        // Backward B with full flush window.
        do_reset();
        tick();
        set_branch(1, 0, 0, 0, 32'h100, 32'hFFFF_FFFC);
        tick();
        clear_inputs();
        for (int n = 0; n < FC; n++) begin
            chk($sformatf("bwd flush pc%0d", n), pc, 32'hF0);
            chk($sformatf("bwd flush%0d", n), 32'(flush), 32'h1);
            chk($sformatf("bwd flush fv%0d", n), 32'(fetchValid), 32'h0);
            tick();
        end
        chk("bwd target fv", 32'(fetchValid), 32'h1);
        chk("bwd target pc", pc, 32'hF0);
        chk("bwd target flush", 32'(flush), 32'h0);
        tick();
        chk("bwd next pc", pc, 32'hF4);
        chk("bwd takenCount", 32'(takenCount), 32'h1);

        // Taken branch held under stall, redirect after stall drops.
        do_reset();
        tick();
        set_branch(1, 0, 0, 0, 32'h100, 32'h10);
        stall = 1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("stall pc%0d", n), pc, 32'h0);
            chk($sformatf("stall fv%0d", n), 32'(fetchValid), 32'h0);
        end
        stall = 0;
        tick();
        clear_inputs();
        chk("stall redirect pc", pc, 32'h140);
        chk("stall redirect flush", 32'(flush), 32'h1);

        // PC increment wraps past the top of the address space.
        do_reset();
        tick();
        set_branch(1, 0, 0, 0, 32'hFFFF_FFF8, 32'h1);
        tick();
        clear_inputs();
        for (int n = 0; n < FC; n++) tick();
        chk("wrap pre pc", pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap pc", pc, 32'h0);
        chk("wrap fv", 32'(fetchValid), 32'h1);

        // Halt during FLUSH freezes the unit against further branches.
        do_reset();
        tick();
        set_branch(1, 0, 0, 0, 32'h200, 32'h0);
        tick();
        clear_inputs();
        halt = 1;
        tick();
        halt = 0;
        chk("halt halted", 32'(halted), 32'h1);
        chk("halt pc", pc, 32'h200);
        chk("halt flush", 32'(flush), 32'h0);
        set_branch(1, 0, 0, 0, 32'h800, 32'h4);
        for (int n = 0; n < 4; n++) begin
            stall = n[0];
            tick();
            chk($sformatf("halt frozen pc%0d", n), pc, 32'h200);
            chk($sformatf("halt frozen fv%0d", n), 32'(fetchValid), 32'h0);
        end
        chk("halt takenCount", 32'(takenCount), 32'h1);
        do_reset();
        chk("halt reset halted", 32'(halted), 32'h0);

        // Saturating taken counter.
        tick();
        for (int n = 0; n < 20; n++) begin
            set_branch(1, 0, 0, 0, 32'h100, 32'h0);
            tick();
            clear_inputs();
            chk($sformatf("sat count%0d", n), 32'(takenCount), 32'((n + 1 > CMAX) ? CMAX : n + 1));
            for (int w = 0; w < FC; w++) tick();
        end
        chk("sat final", 32'(takenCount), 32'd15);

        // Random stimulus against the reference model.
        do_reset();
        begin
            int halt_age = 0;
            for (int n = 0; n < 1500; n++) begin
                if ((m_halted && halt_age > 4) || $urandom_range(0, 299) == 0) begin
                    do_reset();
                    halt_age = 0;
                end
                stall = ($urandom_range(0, 3) == 0);
                halt  = ($urandom_range(0, 99) == 0);
                bv    = ($urandom_range(0, 1) == 1);
                ub    = ($urandom_range(0, 2) == 0);
                cb    = ($urandom_range(0, 1) == 1);
                inv   = ($urandom_range(0, 1) == 1);
                zero  = ($urandom_range(0, 1) == 1);
                bpc   = $urandom;
                off   = $urandom;
                if ($urandom_range(0, 1) == 1) off = 32'($urandom_range(0, 31)) - 32'd16;
                tick();
                if (m_halted) halt_age++;
                chk("rnd pc", pc, m_pc);
                chk("rnd fetchValid", 32'(fetchValid), 32'(m_fv));
                chk("rnd flush", 32'(flush), 32'(m_flush));
                chk("rnd halted", 32'(halted), 32'(m_halted));
                chk("rnd takenCount", 32'(takenCount), 32'(m_cnt));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
